// File: rtl/dz_countdown_if.sv
// Button inputs and status outputs of the dz_countdown sequencer.
interface dz_countdown_if;
  logic       btn_start;
  logic       btn_pause;
  logic       btn_clr;
  logic [2:0] num;
  logic       running;
  logic       done;

  modport master (output btn_start, btn_pause, btn_clr, input num, running, done);
  modport slave  (input btn_start, btn_pause, btn_clr, output num, running, done);
endinterface

// File: rtl/dz_countdown.sv
// Countdown sequencer: debounced start/pause/clear buttons drive a START_VAL..0
// down-counter stepping once every TICK_DIV clocks.
module dz_countdown #(
  parameter int         TICK_DIV        = 1000,
  parameter int         DEBOUNCE_CYCLES = 20,
  parameter logic [2:0] START_VAL       = 3'd5
) (
  input logic           clk,
  input logic           rst,
  dz_countdown_if.slave bus
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [2:0]    raw_s;
  logic [2:0]    sync1_r;
  logic [2:0]    sync2_r;
  logic [2:0]    level_r;
  logic [2:0]    level_d_r;
  logic [2:0]    pulse_r;
  logic [CW-1:0] db_cnt_r [3];
  logic          p_start_s;
  logic          p_pause_s;
  logic          p_clr_s;

  logic [1:0]    state_r;
  logic [1:0]    state_nx_s;
  logic [2:0]    num_r;
  logic [2:0]    num_nx_s;
  logic [TW-1:0] tick_r;
  logic [TW-1:0] tick_nx_s;
  logic          running_r;
  logic          done_r;

  // Bit 0 start, bit 1 pause, bit 2 clear throughout the button path.
  assign raw_s     = {bus.btn_clr, bus.btn_pause, bus.btn_start};
  assign p_start_s = pulse_r[0];
  assign p_pause_s = pulse_r[1];
  assign p_clr_s   = pulse_r[2];

  // Synchronize, debounce and rising-edge detect every button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r   <= 3'b000;
      sync2_r   <= 3'b000;
      level_r   <= 3'b000;
      level_d_r <= 3'b000;
      pulse_r   <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        db_cnt_r[i] <= {CW{1'b0}};
      end
    end else begin
      sync1_r   <= raw_s;
      sync2_r   <= sync1_r;
      level_d_r <= level_r;
      pulse_r   <= level_r & ~level_d_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] != level_r[i]) begin
          if (db_cnt_r[i] == DB_LAST) begin
            level_r[i]  <= sync2_r[i];
            db_cnt_r[i] <= {CW{1'b0}};
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + CW'(1'b1);
          end
        end else begin
          db_cnt_r[i] <= {CW{1'b0}};
        end
      end
    end
  end

  // Next state: clear beats the terminal tick, which beats pause, which beats start.
  always_comb begin
    state_nx_s = state_r;
    num_nx_s   = num_r;
    tick_nx_s  = tick_r;
    if (p_clr_s) begin
      state_nx_s = ST_IDLE;
      num_nx_s   = START_VAL;
      tick_nx_s  = {TW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          num_nx_s  = START_VAL;
          tick_nx_s = {TW{1'b0}};
          if (p_start_s) begin
            state_nx_s = ST_RUN;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (tick_r == TICK_LAST) begin
            tick_nx_s = {TW{1'b0}};
            num_nx_s  = (num_r == 3'd0) ? 3'd0 : num_r - 3'd1;
            if (num_r <= 3'd1) begin
              state_nx_s = ST_DONE;
            end else if (p_pause_s) begin
              state_nx_s = ST_PAUSE;
            end else begin
              state_nx_s = ST_RUN;
            end
          end else begin
            tick_nx_s = tick_r + TW'(1'b1);
            if (p_pause_s) begin
              state_nx_s = ST_PAUSE;
            end else begin
              state_nx_s = ST_RUN;
            end
          end
        end
        ST_PAUSE: begin
          if (p_start_s) begin
            state_nx_s = ST_RUN;
          end else begin
            state_nx_s = ST_PAUSE;
          end
        end
        ST_DONE: begin
          if (p_start_s) begin
            state_nx_s = ST_RUN;
            num_nx_s   = START_VAL;
            tick_nx_s  = {TW{1'b0}};
          end else begin
            state_nx_s = ST_DONE;
            num_nx_s   = 3'd0;
            tick_nx_s  = {TW{1'b0}};
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
          num_nx_s   = START_VAL;
          tick_nx_s  = {TW{1'b0}};
        end
      endcase
    end
  end

  // State, count and status flags; flags decode the next state so they track it exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      num_r     <= START_VAL;
      tick_r    <= {TW{1'b0}};
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      num_r     <= num_nx_s;
      tick_r    <= tick_nx_s;
      running_r <= (state_nx_s == ST_RUN);
      done_r    <= (state_nx_s == ST_DONE);
    end
  end

  assign bus.num     = num_r;
  assign bus.running = running_r;
  assign bus.done    = done_r;

endmodule
